// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arith_pkg
// Purpose : Shared types and constants for the serial arithmetic blocks.
//           Holds the serial FSM state encoding, the default operand width
//           and a helper that sizes the bit counter.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package arith_pkg;

    // Default operand/result width for the serial subtractor.
    localparam int c_default_width = 8;

    // Serial FSM states, explicitly one bit wide.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Bit-counter width: enough to count 0..width-1. Never narrower than
    // one bit so the counter remains a legal vector at the minimum width.
    function automatic int cnt_width(input int width);
        if (width < 2) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage : arith_pkg
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : full_subtractor
// Purpose : One-bit combinational full subtractor, d = a - b - bin.
// Ports   : a    in  1  minuend bit
//           b    in  1  subtrahend bit
//           bin  in  1  borrow in
//           d    out 1  difference bit
//           bout out 1  borrow out
// Rev     : 1.0  initial release
// ============================================================================
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign d     = w_axb ^ bin;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign bout  = (~a & b) | (~w_axb & bin);

endmodule : full_subtractor
`default_nettype wire

// File: rtl/subtractor_8bit_serial.sv
`default_nettype none
// ============================================================================
// Module  : subtractor_8bit_serial
// Purpose : Bit-serial subtractor computing diff = a - b - bin, LSB first,
//           one bit per clock, one result every WIDTH cycles.
// Ports   : clk    in  1      system clock (rising edge)
//           rst_n  in  1      asynchronous active-low reset
//           start  in  1      request a new operation (sampled when ready)
//           a      in  WIDTH  minuend, captured on the accepting edge
//           b      in  WIDTH  subtrahend, captured on the accepting edge
//           bin    in  1      borrow in, captured on the accepting edge
//           ready  out 1      a start will be accepted this cycle
//           done   out 1      one-cycle pulse: diff/bout freshly updated
//           diff   out WIDTH  a - b - bin modulo 2^WIDTH
//           bout   out 1      borrow out (a < b + bin, unsigned)
// Rev     : 1.0  initial release
// ============================================================================
module subtractor_8bit_serial
    import arith_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int                 c_cnt_w = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic               r_brw;
    // Holds the WIDTH-1 bits already produced; the bit computed this cycle
    // completes the word, so the final result is available without an
    // extra shift cycle.
    logic [WIDTH-2:0]   r_res;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_done;

    logic               w_bit;
    logic               w_brw_next;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_accept;
    logic               w_last;

    full_subtractor u_fs (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .bin  (r_brw),
        .d    (w_bit),
        .bout (w_brw_next)
    );

    assign w_res_next = {w_bit, r_res};
    assign w_accept   = (r_state == IDLE) && start;
    assign w_last     = (r_state == RUN) && (r_cnt == c_last);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = RUN;
            RUN:     if (w_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: operand shifters, borrow flop, counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_brw  <= 1'b0;
            r_res  <= '0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a_sh <= a;
                r_b_sh <= b;
                r_brw  <= bin;
                r_cnt  <= '0;
            end else if (r_state == RUN) begin
                r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
                r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
                r_brw  <= w_brw_next;
                r_res  <= w_res_next[WIDTH-1:1];
                r_cnt  <= r_cnt + c_one;
                if (w_last) begin
                    r_diff <= w_res_next;
                    r_bout <= w_brw_next;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign ready = (r_state == IDLE);
    assign done  = r_done;
    assign diff  = r_diff;
    assign bout  = r_bout;

endmodule : subtractor_8bit_serial
`default_nettype wire
